phase_timer: RTL and testbench

PHASE_TIMER -- requirements
Module: phase_timer

---
 rtl/phase_timer.sv | 118 +++++++++++
 tb/tb_phase_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// Two-phase BCD countdown timer: long (green) and short (yellow) countdowns
// driven by a one-second prescaler, with one-cycle expiry pulses per phase.
module phase_timer #(
  parameter logic [7:0]  T_GREEN  = 8'h30,
  parameter logic [7:0]  T_YELLOW = 8'h05,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_long,
  input  logic       start_short,
  input  logic       abort,
  output logic       Timeout,
  output logic       timeout,
  output logic       busy,
  output logic [7:0] count_bcd,
  output logic [1:0] phase
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN_LONG  = 2'b01,
    RUN_SHORT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    count_d;
  logic          long_pulse_d, short_pulse_d, busy_d;
  logic          tick_c;
  logic [7:0]    count_dec_c;

  // One-second tick while the prescaler sits at its last value
  assign tick_c = (presc_q == PW'(TICK_DIV - 1));

  // BCD decrement: units borrow from tens
  always_comb begin
    if (count_bcd[3:0] == 4'h0) begin
      count_dec_c = {count_bcd[7:4] - 4'h1, 4'h9};
    end else begin
      count_dec_c = {count_bcd[7:4], count_bcd[3:0] - 4'h1};
    end
  end

  // Next-state and next-output logic; abort overrides tick and start
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    count_d       = count_bcd;
    long_pulse_d  = 1'b0;
    short_pulse_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_long) begin
            state_d = RUN_LONG;
            count_d = T_GREEN;
            presc_d = '0;
          end else if (start_short) begin
            state_d = RUN_SHORT;
            count_d = T_YELLOW;
            presc_d = '0;
          end
        end
        RUN_LONG, RUN_SHORT: begin
          if (tick_c) begin
            presc_d = '0;
            if (count_bcd == 8'h00) begin
              state_d       = IDLE;
              long_pulse_d  = (state_q == RUN_LONG);
              short_pulse_d = (state_q == RUN_SHORT);
            end else begin
              count_d = count_dec_c;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
          count_d = 8'h00;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_bcd <= 8'h00;
      busy      <= 1'b0;
      phase     <= 2'b00;
      Timeout   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_bcd <= count_d;
      busy      <= busy_d;
      phase     <= 2'(state_d);
      Timeout   <= long_pulse_d;
      timeout   <= short_pulse_d;
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: directed scenarios plus random stimulus, checked
// against a model that derives expected outputs from start time and elapsed cycles.
module tb_phase_timer;

  localparam int unsigned TD = 4;
  localparam logic [7:0]  TG = 8'h12;
  localparam logic [7:0]  TY = 8'h05;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_long = 1'b0;
  logic       start_short = 1'b0;
  logic       abort = 1'b0;
  logic       Timeout, timeout, busy;
  logic [7:0] count_bcd;
  logic [1:0] phase;

  phase_timer #(.T_GREEN(TG), .T_YELLOW(TY), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start_long(start_long), .start_short(start_short),
    .abort(abort), .Timeout(Timeout), .timeout(timeout), .busy(busy),
    .count_bcd(count_bcd), .phase(phase)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  // Model: a countdown is a start edge, a decimal load and a kind
  bit m_active, m_long, m_pl, m_ps;
  int m_start, m_d;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_pl = 1'b0;
    m_ps = 1'b0;
    if (abort) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (e - m_start == (m_d + 1) * int'(TD)) begin
        m_pl     = m_long;
        m_ps     = !m_long;
        m_active = 1'b0;
      end
    end else if (start_long || start_short) begin
      m_active = 1'b1;
      m_long   = start_long;
      m_start  = e;
      m_d      = bcd2int(start_long ? TG : TY);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_cnt;
    logic [1:0] exp_ph;
    exp_cnt = m_active ? int2bcd(m_d - (e - m_start) / int'(TD)) : 8'h00;
    exp_ph  = !m_active ? 2'b00 : (m_long ? 2'b01 : 2'b10);
    chk({tag, "/count"},   32'(count_bcd), 32'(exp_cnt));
    chk({tag, "/busy"},    32'(busy),      32'(m_active));
    chk({tag, "/phase"},   32'(phase),     32'(exp_ph));
    chk({tag, "/Timeout"}, 32'(Timeout),   32'(m_pl));
    chk({tag, "/timeout"}, 32'(timeout),   32'(m_ps));
    chk({tag, "/excl"},    32'(Timeout & timeout), 32'(0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    e++;
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic apply(input bit sl, input bit ss, input bit ab, input string tag);
    start_long  = sl;
    start_short = ss;
    abort       = ab;
    step(tag);
    start_long  = 1'b0;
    start_short = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/count"},   32'(count_bcd), 32'(0));
    chk({tag, "/busy"},    32'(busy),      32'(0));
    chk({tag, "/phase"},   32'(phase),     32'(0));
    chk({tag, "/Timeout"}, 32'(Timeout),   32'(0));
    chk({tag, "/timeout"}, 32'(timeout),   32'(0));
  endtask

  initial begin
    m_active = 1'b0; m_long = 1'b0; m_pl = 1'b0; m_ps = 1'b0;
    m_start = 0; m_d = 0;

    // Reset state, then a start honoured on the first edge after release
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    apply(1'b0, 1'b1, 1'b0, "short_start");
    chk("short_load", 32'(count_bcd), 32'(8'h05));
    for (int i = 1; i <= 24; i++) begin
      step("short_run");
      if (i == 4)  chk("short_n4",  32'(count_bcd), 32'(8'h04));
      if (i == 20) chk("short_n20", 32'(count_bcd), 32'(8'h00));
      if (i == 23) chk("short_nopulse", 32'(timeout), 32'(0));
    end
    chk("short_expiry", 32'(timeout), 32'(1));

    // Long run crossing 10 -> 09, then back-to-back short start
    apply(1'b1, 1'b0, 1'b0, "long_start");
    for (int i = 1; i <= 52; i++) begin
      step("long_run");
      if (i == 8)  chk("long_n8",  32'(count_bcd), 32'(8'h10));
      if (i == 12) chk("long_n12", 32'(count_bcd), 32'(8'h09));
    end
    chk("long_expiry", 32'(Timeout), 32'(1));
    chk("long_busy_off", 32'(busy), 32'(0));
    apply(1'b0, 1'b1, 1'b0, "b2b_start");
    chk("b2b_load", 32'(count_bcd), 32'(8'h05));
    for (int i = 1; i <= 24; i++) step("b2b_run");
    chk("b2b_expiry", 32'(timeout), 32'(1));

    // Simultaneous starts: long wins; later start ignored
    apply(1'b1, 1'b1, 1'b0, "both_start");
    chk("both_phase", 32'(phase), 32'(2'b01));
    chk("both_count", 32'(count_bcd), 32'(8'h12));
    for (int i = 0; i < 3; i++) step("both_run");
    apply(1'b0, 1'b1, 1'b0, "ignored_start");
    chk("ignored_phase", 32'(phase), 32'(2'b01));
    chk("ignored_count", 32'(count_bcd), 32'(8'h11));
    apply(1'b0, 1'b0, 1'b1, "abort_long");

    // Abort beats start at edge N+10 of a short run
    apply(1'b0, 1'b1, 1'b0, "abort_short_start");
    for (int i = 0; i < 9; i++) step("abort_short_run");
    apply(1'b1, 1'b0, 1'b1, "abort_with_start");
    chk("abort_count", 32'(count_bcd), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    apply(1'b1, 1'b0, 1'b0, "restart_long");
    chk("restart_count", 32'(count_bcd), 32'(8'h12));
    for (int i = 0; i < 20; i++) step("pre_reset_run");

    // Asynchronous reset mid-countdown, then no expiry afterwards
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    m_active = 1'b0;
    m_pl = 1'b0;
    m_ps = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step("post_reset");

    // Random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      start_long  = ($urandom_range(0, 9) == 0);
      start_short = ($urandom_range(0, 9) == 0);
      abort       = ($urandom_range(0, 59) == 0);
      step("random");
    end
    start_long  = 1'b0;
    start_short = 1'b0;
    abort       = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
